// File: rtl/alu_seq.sv
// Registered MIPS EX-stage ALU with valid/ready handshake and an iterative
// multiply/divide unit writing internal HI/LO registers.
module alu_seq #(
    parameter int BITS_SIZE  = 32,
    parameter int BITS_SHAMT = 5,
    parameter int BITS_FUNCT = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [BITS_FUNCT-1:0] i_funct,
    input  logic [BITS_SIZE-1:0]  i_data_a,
    input  logic [BITS_SIZE-1:0]  i_data_b,
    input  logic [BITS_SHAMT-1:0] i_alu_shamt,
    output logic [BITS_SIZE-1:0]  o_result,
    output logic                  o_zero,
    output logic                  o_valid,
    output logic                  o_busy
);

    localparam logic [BITS_FUNCT-1:0] F_SLL   = BITS_FUNCT'(6'b000000);
    localparam logic [BITS_FUNCT-1:0] F_SRL   = BITS_FUNCT'(6'b000010);
    localparam logic [BITS_FUNCT-1:0] F_SRA   = BITS_FUNCT'(6'b000011);
    localparam logic [BITS_FUNCT-1:0] F_SLLV  = BITS_FUNCT'(6'b000100);
    localparam logic [BITS_FUNCT-1:0] F_SRLV  = BITS_FUNCT'(6'b000110);
    localparam logic [BITS_FUNCT-1:0] F_SRAV  = BITS_FUNCT'(6'b000111);
    localparam logic [BITS_FUNCT-1:0] F_MFHI  = BITS_FUNCT'(6'b010000);
    localparam logic [BITS_FUNCT-1:0] F_MTHI  = BITS_FUNCT'(6'b010001);
    localparam logic [BITS_FUNCT-1:0] F_MFLO  = BITS_FUNCT'(6'b010010);
    localparam logic [BITS_FUNCT-1:0] F_MTLO  = BITS_FUNCT'(6'b010011);
    localparam logic [BITS_FUNCT-1:0] F_MULT  = BITS_FUNCT'(6'b011000);
    localparam logic [BITS_FUNCT-1:0] F_MULTU = BITS_FUNCT'(6'b011001);
    localparam logic [BITS_FUNCT-1:0] F_DIV   = BITS_FUNCT'(6'b011010);
    localparam logic [BITS_FUNCT-1:0] F_DIVU  = BITS_FUNCT'(6'b011011);
    localparam logic [BITS_FUNCT-1:0] F_ADD   = BITS_FUNCT'(6'b100000);
    localparam logic [BITS_FUNCT-1:0] F_SUB   = BITS_FUNCT'(6'b100010);
    localparam logic [BITS_FUNCT-1:0] F_AND   = BITS_FUNCT'(6'b100100);
    localparam logic [BITS_FUNCT-1:0] F_OR    = BITS_FUNCT'(6'b100101);
    localparam logic [BITS_FUNCT-1:0] F_XOR   = BITS_FUNCT'(6'b100110);
    localparam logic [BITS_FUNCT-1:0] F_NOR   = BITS_FUNCT'(6'b100111);
    localparam logic [BITS_FUNCT-1:0] F_SLT   = BITS_FUNCT'(6'b101010);
    localparam logic [BITS_FUNCT-1:0] F_SLTU  = BITS_FUNCT'(6'b101011);
    localparam logic [BITS_SHAMT-1:0] CNT_LAST = BITS_SHAMT'(BITS_SIZE - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t                   state, state_next;
    logic [BITS_SHAMT-1:0]    cnt;
    logic [2*BITS_SIZE-1:0]   acc, acc_next, prod;
    logic [BITS_SIZE-1:0]     opnd, hi, lo, alu_res, fin_hi, fin_lo, mag_a, mag_b;
    logic [BITS_SIZE:0]       mul_sum, rem_shift, diff;
    logic                     neg_q, neg_r, is_div, b_zero, sign_a, sign_b;
    logic                     accept, is_multi, last_step;

    always_comb begin
        is_multi = (i_funct == F_MULT) || (i_funct == F_MULTU) ||
                   (i_funct == F_DIV)  || (i_funct == F_DIVU);
        accept   = i_valid && (state == IDLE);
        last_step = (state == RUN) && (cnt == CNT_LAST);
        sign_a   = ~i_funct[0] & i_data_a[BITS_SIZE-1];
        sign_b   = ~i_funct[0] & i_data_b[BITS_SIZE-1];
        mag_a    = sign_a ? -i_data_a : i_data_a;
        mag_b    = sign_b ? -i_data_b : i_data_b;
    end

    always_comb begin
        alu_res = '0;
        case (i_funct)
            F_ADD:   alu_res = i_data_a + i_data_b;
            F_SUB:   alu_res = i_data_a - i_data_b;
            F_AND:   alu_res = i_data_a & i_data_b;
            F_OR:    alu_res = i_data_a | i_data_b;
            F_XOR:   alu_res = i_data_a ^ i_data_b;
            F_NOR:   alu_res = ~(i_data_a | i_data_b);
            F_SLT:   alu_res = BITS_SIZE'($signed(i_data_a) < $signed(i_data_b));
            F_SLTU:  alu_res = BITS_SIZE'(i_data_a < i_data_b);
            F_SLL:   alu_res = i_data_b << i_alu_shamt;
            F_SRL:   alu_res = i_data_b >> i_alu_shamt;
            F_SRA:   alu_res = $signed(i_data_b) >>> i_alu_shamt;
            F_SLLV:  alu_res = i_data_b << i_data_a[BITS_SHAMT-1:0];
            F_SRLV:  alu_res = i_data_b >> i_data_a[BITS_SHAMT-1:0];
            F_SRAV:  alu_res = $signed(i_data_b) >>> i_data_a[BITS_SHAMT-1:0];
            F_MFHI:  alu_res = hi;
            F_MFLO:  alu_res = lo;
            F_MTHI:  alu_res = i_data_a;
            F_MTLO:  alu_res = i_data_a;
            default: alu_res = '0;
        endcase
    end

    // Upper half of acc is the running partial product / remainder, lower half
    // the multiplier / dividend being shifted out.
    always_comb begin
        mul_sum   = {1'b0, acc[2*BITS_SIZE-1:BITS_SIZE]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_shift = {acc[2*BITS_SIZE-1:BITS_SIZE], acc[BITS_SIZE-1]};
        diff      = rem_shift - {1'b0, opnd};
        if (!is_div)
            acc_next = {mul_sum, acc[BITS_SIZE-1:1]};
        else if (diff[BITS_SIZE])
            acc_next = {rem_shift[BITS_SIZE-1:0], acc[BITS_SIZE-2:0], 1'b0};
        else
            acc_next = {diff[BITS_SIZE-1:0], acc[BITS_SIZE-2:0], 1'b1};
        prod = neg_q ? -acc_next : acc_next;
        if (is_div) begin
            fin_lo = b_zero ? '1 :
                     (neg_q ? -acc_next[BITS_SIZE-1:0] : acc_next[BITS_SIZE-1:0]);
            fin_hi = neg_r ? -acc_next[2*BITS_SIZE-1:BITS_SIZE]
                           : acc_next[2*BITS_SIZE-1:BITS_SIZE];
        end else begin
            fin_lo = prod[BITS_SIZE-1:0];
            fin_hi = prod[2*BITS_SIZE-1:BITS_SIZE];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_multi) state_next = RUN;
            RUN:     if (cnt == CNT_LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        o_busy  = (state != IDLE);
        o_ready = ~o_busy;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    // The corrected result is registered on the final RUN step so that it is
    // presented during the FIX cycle, keeping o_busy high for BITS_SIZE+1 cycles.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_div   <= 1'b0;
            b_zero   <= 1'b0;
            o_result <= '0;
            o_zero   <= 1'b1;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (accept && is_multi) begin
                cnt    <= '0;
                is_div <= i_funct[1];
                b_zero <= (i_data_b == '0);
                neg_q  <= sign_a ^ sign_b;
                neg_r  <= sign_a;
                acc    <= {{BITS_SIZE{1'b0}}, (i_funct[1] ? mag_a : mag_b)};
                opnd   <= i_funct[1] ? mag_b : mag_a;
            end else if (accept) begin
                o_result <= alu_res;
                o_zero   <= (alu_res == '0);
                o_valid  <= 1'b1;
                if (i_funct == F_MTHI) hi <= i_data_a;
                if (i_funct == F_MTLO) lo <= i_data_a;
            end else if (state == RUN) begin
                acc <= acc_next;
                cnt <= last_step ? '0 : cnt + 1'b1;
                if (last_step) begin
                    hi       <= fin_hi;
                    lo       <= fin_lo;
                    o_result <= fin_lo;
                    o_zero   <= (fin_lo == '0);
                    o_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes model results, a negedge
// monitor pops and compares on every o_valid pulse.
module tb_alu_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic          ready, zero, valid_out, busy;
    logic [5:0]    funct = '0;
    logic [W-1:0]  a = '0, b = '0, result;
    logic [4:0]    shamt = '0;

    int            errors = 0;
    int            checks = 0;
    logic [W-1:0]  expq[$];
    logic [W-1:0]  mhi = '0, mlo = '0;
    logic [W-1:0]  last_res = '0;
    logic          last_zero = 1'b1;

    alu_seq #(.BITS_SIZE(W), .BITS_SHAMT(5), .BITS_FUNCT(6)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid_in), .o_ready(ready),
        .i_funct(funct), .i_data_a(a), .i_data_b(b), .i_alu_shamt(shamt),
        .o_result(result), .o_zero(zero), .o_valid(valid_out), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural meaning of each function code.
    task automatic model(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [4:0] sh, output logic [W-1:0] r);
        longint      sx, sy, q, rm;
        logic [63:0] p, qv, rv;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r = '0;
        case (f)
            6'b100000: r = x + y;
            6'b100010: r = x - y;
            6'b100100: r = x & y;
            6'b100101: r = x | y;
            6'b100110: r = x ^ y;
            6'b100111: r = ~(x | y);
            6'b101010: r = (sx < sy) ? 32'd1 : 32'd0;
            6'b101011: r = (x < y) ? 32'd1 : 32'd0;
            6'b000000: r = y << sh;
            6'b000010: r = y >> sh;
            6'b000011: r = W'($signed(y) >>> sh);
            6'b000100: r = y << x[4:0];
            6'b000110: r = y >> x[4:0];
            6'b000111: r = W'($signed(y) >>> x[4:0]);
            6'b010000: r = mhi;
            6'b010010: r = mlo;
            6'b010001: begin mhi = x; r = x; end
            6'b010011: begin mlo = x; r = x; end
            6'b011000: begin p = 64'(sx * sy); mhi = p[63:32]; mlo = p[31:0]; r = mlo; end
            6'b011001: begin p = {32'd0, x} * {32'd0, y}; mhi = p[63:32]; mlo = p[31:0]; r = mlo; end
            6'b011010: begin
                if (y == 0) begin mlo = '1; mhi = x; end
                else begin
                    q = sx / sy; rm = sx % sy;
                    qv = 64'(q); rv = 64'(rm);
                    mlo = qv[31:0]; mhi = rv[31:0];
                end
                r = mlo;
            end
            6'b011011: begin
                if (y == 0) begin mlo = '1; mhi = x; end
                else begin mlo = x / y; mhi = x % y; end
                r = mlo;
            end
            default: r = '0;
        endcase
    endtask

    // Called at posedge+1; waits for ready, presents the request for one edge.
    task automatic issue(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [4:0] sh);
        logic [W-1:0] r;
        int t = 0;
        while (!ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!ready) begin
            errors++; checks++;
            $display("FAIL ready_timeout: got o_ready=%b expected 1", ready);
        end
        model(f, x, y, sh, r);
        expq.push_back(r);
        valid_in = 1'b1; funct = f; a = x; b = y; shamt = sh;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    always @(posedge clk) begin
        if (rst) begin last_res = '0; last_zero = 1'b1; end
    end

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (valid_out === 1'b1) begin
            if (expq.size() == 0) begin
                errors++; checks++;
                $display("FAIL unexpected_valid: got result %h expected no pulse", result);
            end else begin
                e = expq.pop_front();
                chk("result", result, e);
                chk("zero", W'(zero), W'(e == '0));
                last_res = e; last_zero = (e == '0);
            end
        end else begin
            chk("hold_result", result, last_res);
            chk("hold_zero", W'(zero), W'(last_zero));
        end
    end

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int busy_cnt, vcyc, vcnt, rdy_cyc, t;
        logic [5:0] codes [22] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                                   6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                                   6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_result", result, '0);
        chk("rst_zero", W'(zero), 32'd1);
        chk("rst_valid", W'(valid_out), 32'd0);
        chk("rst_busy", W'(busy), 32'd0);
        chk("rst_ready", W'(ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // MULT latency, busy window and ignored request during busy
        issue(6'b011000, 32'hFFFF_FFFE, 32'd3, 5'd0);
        busy_cnt = 0; vcyc = 0; vcnt = 0; rdy_cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (valid_out) begin vcnt++; vcyc = k; end
            if (ready && rdy_cyc == 0) rdy_cyc = k;
            if (k == 5) begin valid_in = 1'b1; funct = 6'b100000; a = 32'd1; b = 32'd2; end
            if (k == 6) valid_in = 1'b0;
        end
        @(posedge clk); #1;
        chk("mult_busy_cycles", W'(busy_cnt), 32'd33);
        chk("mult_valid_cycle", W'(vcyc), 32'd33);
        chk("mult_valid_count", W'(vcnt), 32'd1);
        chk("mult_ready_cycle", W'(rdy_cyc), 32'd34);

        issue(6'b010000, '0, '0, 5'd0);
        issue(6'b011001, 32'hFFFF_FFFE, 32'd3, 5'd0);
        issue(6'b010000, '0, '0, 5'd0);
        issue(6'b010010, '0, '0, 5'd0);
        issue(6'b011010, 32'hFFFF_FFF9, 32'd2, 5'd0);
        issue(6'b010000, '0, '0, 5'd0);
        issue(6'b011011, 32'd7, 32'd0, 5'd0);
        issue(6'b010000, '0, '0, 5'd0);
        issue(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        issue(6'b010000, '0, '0, 5'd0);
        issue(6'b011010, 32'hFFFF_FFF9, 32'd0, 5'd0);
        issue(6'b010000, '0, '0, 5'd0);
        issue(6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0);
        issue(6'b101011, 32'hFFFF_FFFF, 32'd1, 5'd0);
        issue(6'b000111, 32'd4, 32'h8000_0000, 5'd0);
        issue(6'b100010, 32'd5, 32'd5, 5'd0);
        issue(6'b111111, 32'd5, 32'd9, 5'd0);
        issue(6'b010011, 32'h1234, '0, 5'd0);
        issue(6'b010010, '0, '0, 5'd0);

        // Reset in the middle of a divide
        issue(6'b011010, 32'd100, 32'd7, 5'd0);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        expq.delete(); mhi = '0; mlo = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready", W'(ready), 32'd1);
        chk("midrst_busy", W'(busy), 32'd0);
        repeat (40) begin @(posedge clk); #1; end
        issue(6'b010010, '0, '0, 5'd0);

        // Reset coincident with a request drops the request
        rst = 1'b1; valid_in = 1'b1; funct = 6'b010011; a = 32'h55;
        @(posedge clk); #1;
        rst = 1'b0; valid_in = 1'b0;
        issue(6'b010010, '0, '0, 5'd0);

        for (int n = 0; n < 80; n++)
            issue(codes[$urandom_range(0, 21)], pick(), pick(), 5'($urandom_range(0, 31)));

        t = 0;
        while (expq.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
        chk("drain", W'(expq.size()), 32'd0);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
